// File: rtl/omap_wr_sched.sv
// Layer write scheduler: packs merged bytes (or passes raw words) from the map merger into omap SRAM writes.
// Optional build macro OMAP_WR_PERF_CNT_EN adds the perf_stall_cnt output.
module omap_wr_sched #(
    parameter int AW    = 16,
    parameter int DIM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic [DIM_W-1:0] cfg_omap_w,
    input  logic [DIM_W-1:0] cfg_omap_h,
    input  logic [AW-1:0]    cfg_base_addr,
    input  logic             cfg_raw_mode,
    input  logic [31:0]      map_merger2omap_biu_data,
    input  logic             map_merger2omap_biu_vld,
    output logic             map_merger2omap_biu_rdy,
    output logic             omap_sram_wr_vld,
    input  logic             omap_sram_wr_rdy,
    output logic [AW-1:0]    omap_sram_wr_addr,
    output logic [31:0]      omap_sram_wr_data,
    output logic             sched_busy,
    output logic             sched_done
`ifdef OMAP_WR_PERF_CNT_EN
    ,
    output logic [31:0]      perf_stall_cnt
`endif
);

    localparam int PW = 2 * DIM_W;

    // Handshakes: an input pixel transfers when vld & rdy on a rising edge; an SRAM
    // write transfers when wr_vld & wr_rdy, and wr_vld/addr/data hold until then.
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  total, pix_cnt;
    logic [AW-1:0]  base_q, word_cnt;
    logic           raw_q;
    logic [1:0]     idx;
    logic [31:0]    pack, pack_nxt;
    logic           wr_free, accept, last_pix, issue;

    assign wr_free  = ~omap_sram_wr_vld | omap_sram_wr_rdy;
    assign map_merger2omap_biu_rdy = (state == RUN) & wr_free;
    assign accept   = map_merger2omap_biu_vld & map_merger2omap_biu_rdy;
    assign last_pix = (pix_cnt == total - PW'(1));
    assign issue    = accept & (raw_q | (idx == 2'd3) | last_pix);

    assign sched_busy = (state != IDLE);
    assign sched_done = (state == DONE);

    always_comb begin
        pack_nxt = pack;
        pack_nxt[{idx, 3'b000} +: 8] = map_merger2omap_biu_data[23:16];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    if ((cfg_omap_w == '0) || (cfg_omap_h == '0)) state_nxt = DONE;
                    else                                          state_nxt = RUN;
                end
            end
            RUN:     if (accept && last_pix) state_nxt = FLUSH;
            FLUSH:   if (wr_free) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total    <= '0;
            base_q   <= '0;
            raw_q    <= 1'b0;
            pix_cnt  <= '0;
            idx      <= '0;
            pack     <= '0;
            word_cnt <= '0;
        end else if (state == IDLE) begin
            pix_cnt  <= '0;
            idx      <= '0;
            pack     <= '0;
            word_cnt <= '0;
            if (cfg_start) begin
                total  <= PW'(cfg_omap_w) * PW'(cfg_omap_h);
                base_q <= cfg_base_addr;
                raw_q  <= cfg_raw_mode;
            end
        end else begin
            if (accept) begin
                pix_cnt <= pix_cnt + PW'(1);
                idx     <= idx + 2'd1;
                // A finished word leaves the pack register clean so a partial tail is zero-filled.
                pack    <= issue ? '0 : pack_nxt;
            end
            if (issue) word_cnt <= word_cnt + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            omap_sram_wr_vld  <= 1'b0;
            omap_sram_wr_addr <= '0;
            omap_sram_wr_data <= '0;
        end else if (issue) begin
            omap_sram_wr_vld  <= 1'b1;
            omap_sram_wr_addr <= base_q + word_cnt;
            omap_sram_wr_data <= raw_q ? map_merger2omap_biu_data : pack_nxt;
        end else if (omap_sram_wr_rdy) begin
            omap_sram_wr_vld  <= 1'b0;
        end
    end

`ifdef OMAP_WR_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
        end else if ((state == IDLE) && cfg_start) begin
            perf_stall_cnt <= '0;
        end else if ((state == RUN) && map_merger2omap_biu_vld && !map_merger2omap_biu_rdy
                     && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_omap_wr_sched.sv
// Bench for omap_wr_sched: random and directed layers checked against a queue-based write model.
module tb_omap_wr_sched;

    localparam int AW    = 16;
    localparam int DIM_W = 8;

    logic             clk;
    logic             rst_n;
    logic             cfg_start;
    logic [DIM_W-1:0] cfg_omap_w;
    logic [DIM_W-1:0] cfg_omap_h;
    logic [AW-1:0]    cfg_base_addr;
    logic             cfg_raw_mode;
    logic [31:0]      in_data;
    logic             in_vld;
    logic             in_rdy;
    logic             wr_vld;
    logic             wr_rdy;
    logic [AW-1:0]    wr_addr;
    logic [31:0]      wr_data;
    logic             sched_busy;
    logic             sched_done;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int rdy_mode = 0;

    logic [AW+31:0] exp_q[$];
    logic [31:0]    pix[$];

    omap_wr_sched #(.AW(AW), .DIM_W(DIM_W)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .cfg_start                (cfg_start),
        .cfg_omap_w               (cfg_omap_w),
        .cfg_omap_h               (cfg_omap_h),
        .cfg_base_addr            (cfg_base_addr),
        .cfg_raw_mode             (cfg_raw_mode),
        .map_merger2omap_biu_data (in_data),
        .map_merger2omap_biu_vld  (in_vld),
        .map_merger2omap_biu_rdy  (in_rdy),
        .omap_sram_wr_vld         (wr_vld),
        .omap_sram_wr_rdy         (wr_rdy),
        .omap_sram_wr_addr        (wr_addr),
        .omap_sram_wr_data        (wr_data),
        .sched_busy               (sched_busy),
        .sched_done               (sched_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // SRAM ready generator for random mode
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) wr_rdy = 1'($urandom_range(0, 1));
        end
    end

    // monitor / scoreboard
    initial begin
        logic           prev_pend;
        logic [AW-1:0]  held_a;
        logic [31:0]    held_d;
        logic [AW+31:0] e;
        prev_pend = 1'b0;
        held_a = '0;
        held_d = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_pend = 1'b0;
            end else begin
                if (prev_pend)
                    check_eq("wr_hold", {15'd0, wr_vld, wr_addr, wr_data}, {15'd0, 1'b1, held_a, held_d});
                if (wr_vld && !wr_rdy)
                    check_eq("in_rdy_blocked", 64'(in_rdy), 64'd0);
                if (wr_vld && wr_rdy) begin
                    writes++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual=%h_%h required=none", wr_addr, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("wr_addr_data", {16'd0, wr_addr, wr_data}, {16'd0, e});
                    end
                end
                prev_pend = wr_vld && !wr_rdy;
                held_a = wr_addr;
                held_d = wr_data;
            end
        end
    end

    // reference model: expected write list for a whole layer
    task automatic push_expected(input int n, input logic [AW-1:0] base, input logic raw);
        logic [AW-1:0] a;
        logic [31:0]   d;
        if (raw) begin
            for (int i = 0; i < n; i++) begin
                a = base + AW'(i);
                exp_q.push_back({a, pix[i]});
            end
        end else begin
            for (int k = 0; k < (n + 3) / 4; k++) begin
                d = '0;
                for (int j = 0; j < 4; j++)
                    if (4 * k + j < n) d[8*j +: 8] = pix[4*k+j][23:16];
                a = base + AW'(k);
                exp_q.push_back({a, d});
            end
        end
    endtask

    // drivers
    task automatic start_layer(input int w, input int h, input logic [AW-1:0] base, input logic raw);
        @(posedge clk);
        #1;
        cfg_omap_w    = DIM_W'(w);
        cfg_omap_h    = DIM_W'(h);
        cfg_base_addr = base;
        cfg_raw_mode  = raw;
        cfg_start     = 1'b1;
        @(posedge clk);
        #1;
        cfg_start     = 1'b0;
    endtask

    task automatic send_pixel(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        in_vld  = 1'b1;
        in_data = d;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (in_rdy) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        check_eq("pixel_accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (sched_done) seen = 1'b1;
        end
        check_eq("done_seen", 64'(seen), 64'd1);
        check_eq("all_writes_done", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check_eq("done_one_cycle", 64'(sched_done), 64'd0);
        check_eq("busy_fell", 64'(sched_busy), 64'd0);
    endtask

    task automatic run_layer(input int w, input int h, input logic [AW-1:0] base, input logic raw,
                             input bit inject, input bit stall);
        int n;
        n = w * h;
        push_expected(n, base, raw);
        start_layer(w, h, base, raw);
        for (int i = 0; i < n; i++) begin
            if (inject && i == 2) begin
                // a start mid-layer must change nothing
                cfg_start     = 1'b1;
                cfg_omap_w    = 8'd9;
                cfg_omap_h    = 8'd9;
                cfg_base_addr = 16'h5A5A;
                cfg_raw_mode  = ~raw;
                fork
                    begin
                        @(posedge clk);
                        #1;
                        cfg_start = 1'b0;
                    end
                join_none
            end
            if (stall && i == 1) begin
                fork
                    begin
                        repeat (5) @(posedge clk);
                        #1;
                        wr_rdy = 1'b1;
                    end
                join_none
            end
            send_pixel(pix[i]);
            if (rdy_mode == 1 && $urandom_range(0, 3) == 0) begin
                in_vld = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        in_vld = 1'b0;
        wait_done();
    endtask

    task automatic set_merged(input logic [7:0] b);
        logic [31:0] d;
        d = $urandom;
        d[23:16] = b;
        pix.push_back(d);
    endtask

    // main sequence
    initial begin
        int w, h, wcount;
        logic [AW-1:0] base;
        logic raw;
        rst_n = 1'b0;
        cfg_start = 1'b0;
        cfg_omap_w = '0;
        cfg_omap_h = '0;
        cfg_base_addr = '0;
        cfg_raw_mode = 1'b0;
        in_data = '0;
        in_vld = 1'b0;
        wr_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wr_vld", 64'(wr_vld), 64'd0);
        check_eq("rst_wr_addr", 64'(wr_addr), 64'd0);
        check_eq("rst_wr_data", 64'(wr_data), 64'd0);
        check_eq("rst_in_rdy", 64'(in_rdy), 64'd0);
        check_eq("rst_busy", 64'(sched_busy), 64'd0);
        check_eq("rst_done", 64'(sched_done), 64'd0);
        rst_n = 1'b1;

        // 2x2 packed into one word
        pix.delete();
        set_merged(8'h11); set_merged(8'h22); set_merged(8'h33); set_merged(8'h44);
        run_layer(2, 2, 16'h0100, 1'b0, 1'b0, 1'b0);

        // 3x2 with a zero-filled partial tail
        pix.delete();
        for (int i = 1; i <= 6; i++) set_merged(8'(i));
        wcount = writes;
        run_layer(3, 2, 16'h0010, 1'b0, 1'b0, 1'b0);
        check_eq("two_writes", 64'(writes - wcount), 64'd2);

        // raw mode
        pix.delete();
        pix.push_back(32'hAABBCCDD); pix.push_back(32'h11223344); pix.push_back(32'h55667788);
        run_layer(1, 3, 16'h0200, 1'b1, 1'b0, 1'b0);

        // SRAM back-pressure while a write is pending
        rdy_mode = 2;
        wr_rdy = 1'b0;
        pix.delete();
        for (int i = 0; i < 3; i++) pix.push_back($urandom);
        run_layer(1, 3, 16'h0020, 1'b1, 1'b0, 1'b1);

        // address wrap with an ignored mid-layer start
        wr_rdy = 1'b1;
        pix.delete();
        for (int i = 0; i < 8; i++) set_merged(8'($urandom));
        run_layer(8, 1, 16'hFFFF, 1'b0, 1'b1, 1'b0);

        // zero-size layer: done with no writes
        wcount = writes;
        start_layer(0, 3, 16'h0777, 1'b0);
        @(negedge clk);
        check_eq("zero_dim_done", 64'(sched_done), 64'd1);
        @(negedge clk);
        check_eq("zero_dim_idle", 64'(sched_busy), 64'd0);
        check_eq("zero_dim_no_writes", 64'(writes - wcount), 64'd0);

        // reset with a write pending
        wr_rdy = 1'b0;
        pix.delete();
        for (int i = 0; i < 8; i++) set_merged(8'($urandom));
        push_expected(8, 16'h0300, 1'b0);
        start_layer(4, 2, 16'h0300, 1'b0);
        for (int i = 0; i < 4; i++) send_pixel(pix[i]);
        in_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_wr_vld", 64'(wr_vld), 64'd0);
        check_eq("midrst_wr_addr", 64'(wr_addr), 64'd0);
        check_eq("midrst_wr_data", 64'(wr_data), 64'd0);
        check_eq("midrst_busy", 64'(sched_busy), 64'd0);
        check_eq("midrst_in_rdy", 64'(in_rdy), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_rdy = 1'b1;
        pix.delete();
        for (int i = 0; i < 3; i++) set_merged(8'($urandom));
        run_layer(3, 1, 16'h0400, 1'b0, 1'b0, 1'b0);

        // randomized layers with random SRAM ready
        rdy_mode = 1;
        for (int r = 0; r < 10; r++) begin
            w = $urandom_range(1, 5);
            h = $urandom_range(1, 4);
            base = 16'($urandom);
            raw = 1'($urandom_range(0, 1));
            pix.delete();
            for (int i = 0; i < w * h; i++) pix.push_back($urandom);
            run_layer(w, h, base, raw, (w * h > 2) && (r % 2 == 1), 1'b0);
        end

        rdy_mode = 0;
        wr_rdy = 1'b1;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
